// File: rtl/dp_ram_be_init.sv
// Dual-port RAM: port 0 writes with byte-lane enables, port 1 reads, and a sweep fills every word with INIT_VALUE.
// Latency: a read presented before an edge returns after that edge, plus RD_PIPE more cycles. The sweep takes DEPTH cycles.
// Backpressure: none. One read per cycle when READY. Both ports are ignored while init_busy is high.
module dp_ram_be_init #(
  parameter int                          DATA_RAM_WIDTH = 32,
  parameter int                          ADDR_WIDTH     = 8,
  parameter int                          BYTE_WIDTH     = 8,
  parameter int                          RD_PIPE        = 0,
  parameter int                          RDW_MODE       = 0,
  parameter logic [DATA_RAM_WIDTH-1:0]   INIT_VALUE     = '0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ADDR_WIDTH-1:0]                  address_0,
  input  logic                                   chip_enable_0,
  input  logic                                   write_read_0,
  input  logic [DATA_RAM_WIDTH/BYTE_WIDTH-1:0]   byte_en_0,
  input  logic [DATA_RAM_WIDTH-1:0]              data_0,
  input  logic [ADDR_WIDTH-1:0]                  address_1,
  input  logic                                   chip_enable_1,
  input  logic                                   write_read_1,
  output logic [DATA_RAM_WIDTH-1:0]              data_1,
  output logic                                   data_1_valid,
  input  logic                                   clear,
  output logic                                   init_busy,
  output logic                                   collision
);

  localparam int NB    = DATA_RAM_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  state_t                    r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_RAM_WIDTH-1:0] r_mem [DEPTH];

  logic                      w_sweep_we, w_wr_acc, w_rd_acc, w_col;
  logic [DATA_RAM_WIDTH-1:0] w_merged;

  logic                      r_s1_vld, r_s1_col;
  logic [DATA_RAM_WIDTH-1:0] r_s1_dat;

  // The sweep write is gated by rst_n so that the array is never written while reset is held.
  assign w_sweep_we = rst_n & (r_state == S_INIT);
  assign w_wr_acc   = (r_state == S_READY) & chip_enable_0 & write_read_0;
  assign w_rd_acc   = (r_state == S_READY) & chip_enable_1 & ~write_read_1;
  assign w_col      = w_wr_acc & w_rd_acc & (address_0 == address_1);
  assign init_busy  = (r_state == S_INIT);

  // State and sweep counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: step the sweep until the last word is written. A clear request only takes effect in READY.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) w_state_nxt = S_READY;
      end
      S_READY: begin
        if (clear) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Array writes come from the sweep or from port 0. The array itself has no reset.
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_mem[r_cnt] <= INIT_VALUE;
    end else if (w_wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en_0[i]) r_mem[address_0][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Lane-merged view of the read word: enabled lanes take port 0 data. Used when a same-address write forwards its data to the read.
  always_comb begin
    w_merged = r_mem[address_1];
    for (int i = 0; i < NB; i++) begin
      if (byte_en_0[i]) w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = data_0[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // First read stage: capture the word when a read is accepted, otherwise hold the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_col <= 1'b0;
      r_s1_dat <= '0;
    end else begin
      r_s1_vld <= w_rd_acc;
      r_s1_col <= w_col;
      if (w_rd_acc) r_s1_dat <= (RDW_MODE == 1 && w_col) ? w_merged : r_mem[address_1];
    end
  end

  if (RD_PIPE == 1) begin : g_pipe
    logic                      r_s2_vld, r_s2_col;
    logic [DATA_RAM_WIDTH-1:0] r_s2_dat;

    // Optional output stage: move valid and collision along, and hold data between results.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_vld <= 1'b0;
        r_s2_col <= 1'b0;
        r_s2_dat <= '0;
      end else begin
        r_s2_vld <= r_s1_vld;
        r_s2_col <= r_s1_col;
        if (r_s1_vld) r_s2_dat <= r_s1_dat;
      end
    end

    assign data_1       = r_s2_dat;
    assign data_1_valid = r_s2_vld;
    assign collision    = r_s2_col;
  end else begin : g_nopipe
    assign data_1       = r_s1_dat;
    assign data_1_valid = r_s1_vld;
    assign collision    = r_s1_col;
  end

endmodule

// File: doc/dp_ram_be_init.md
DP_RAM_BE_INIT -- requirements
Module: dp_ram_be_init

Interface
REQ-001 SHALL have parameter DATA_RAM_WIDTH, default 32, data word width in bits; legal values are multiples of BYTE_WIDTH.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; depth DEPTH = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, bits per byte lane; NB = DATA_RAM_WIDTH/BYTE_WIDTH lanes.
REQ-004 SHALL have parameter RD_PIPE, default 0, extra read output register stages (0 or 1).
REQ-005 SHALL have parameter RDW_MODE, default 0, same-address read-during-write result: 0 = old data, 1 = new data.
REQ-006 SHALL have parameter INIT_VALUE, default 0, DATA_RAM_WIDTH-bit value written to every word by the init sweep.
REQ-007 Ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- address_0  in  ADDR_WIDTH  port 0 write address
- chip_enable_0  in  1  port 0 enable
- write_read_0  in  1  port 0 write when 1 (reads not supported on port 0)
- byte_en_0  in  NB  port 0 byte-lane write enables
- data_0  in  DATA_RAM_WIDTH  port 0 write data
- address_1  in  ADDR_WIDTH  port 1 read address
- chip_enable_1  in  1  port 1 enable
- write_read_1  in  1  port 1 read when 0 (port 1 never writes)
- data_1  out  DATA_RAM_WIDTH  port 1 read data
- data_1_valid  out  1  data_1 carries a new read result this cycle
- clear  in  1  single-cycle request to re-run the init sweep
- init_busy  out  1  init sweep in progress
- collision  out  1  same-address write/read event flag
REQ-008 Clock is clk, reset is rst_n: one clock, reset asynchronous and active-low.

Function
REQ-009 SHALL implement FSM states INIT and READY; reset enters INIT with sweep counter = 0.
REQ-010 In INIT, SHALL write INIT_VALUE to address = counter each cycle, counter +1; after writing DEPTH-1, next state READY (sweep = exactly DEPTH cycles).
REQ-011 init_busy SHALL be 1 exactly while state is INIT (registered from state).
REQ-012 In INIT, port 0 writes and port 1 reads SHALL be ignored; no data_1_valid generated.
REQ-013 clear=1 in READY SHALL move to INIT next cycle with counter = 0; clear in INIT SHALL be ignored (no restart).
REQ-014 In READY, write occurs when chip_enable_0 & write_read_0; only lanes with byte_en_0[i]=1 updated; byte_en_0 = 0 is a no-op.
REQ-015 In READY, read accepted when chip_enable_1 & !write_read_1; chip_enable_1 & write_read_1 SHALL do nothing.
REQ-016 Read accepted at edge N SHALL present data_1 and data_1_valid=1 after edge N+1+RD_PIPE; valid high one cycle per accepted read; fully pipelined, one read/cycle.
REQ-017 data_1 SHALL hold its last value when data_1_valid = 0.
REQ-018 Same-cycle write and read to the same address: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns lane-merged word (enabled lanes from data_0, others old).
REQ-019 collision SHALL be 1 in the same cycle data_1_valid is 1 for a read that hit REQ-018, else 0.
REQ-020 Reads in flight when clear is accepted SHALL still complete with pre-clear contents per REQ-016.
REQ-021 Addresses SHALL be full-range; no out-of-range case exists.

Reset
REQ-022 rst_n low SHALL asynchronously force: state INIT, counter 0, init_busy 1, data_1 0, data_1_valid 0, collision 0, pipeline valids 0.
REQ-023 Memory array SHALL NOT be reset directly; contents become INIT_VALUE only via the sweep.
REQ-024 Reset asserted mid-sweep or mid-read SHALL discard all in-flight reads and restart the sweep at 0 after release.

Verification
REQ-025 Release reset, DEPTH=256 -> init_busy high 256 cycles then low; reads of 0x00, 0x7F, 0xFF return INIT_VALUE.
REQ-026 Write 0xDEADBEEF @0x10 (be=4'hF), then be=4'b0101 data 0x11223344 -> read 0x10 = 0xDE22BE44, valid at latency 1 (RD_PIPE=0) and 2 (RD_PIPE=1).
REQ-027 Same-cycle write 0xAAAAAAAA @0x20 (old 0x55555555) with read @0x20 -> RDW_MODE=0: 0x55555555, RDW_MODE=1: 0xAAAAAAAA; collision=1 with valid.
REQ-028 Back-to-back reads 0x00..0x07 -> 8 consecutive valid cycles in order, no gaps.
REQ-029 clear pulse while data at 0x30 = 0x12345678 -> init_busy 256 cycles, port 0/1 ignored meanwhile, then 0x30 reads INIT_VALUE.
REQ-030 Assert rst_n low at sweep count 100 with a read in flight -> valid stays 0, sweep restarts at 0, init_busy 256 cycles after release.
